mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between two pipeline requesters:
//  the IF-stage instruction fetch and the MEM-stage load/store.
//  Sits between pipelinedProcessor and the memory model.
//  Grants one transaction at a time and returns read data with a 1-cycle valid pulse.
//  Exports stall_if/stall_mem, which freeze the PC, IF_ID and EX_MEM/MEM_WB registers.
// PARAMETERS
//  XLEN             64  address and data width
//  ILEN             32  instruction width; if_instr = mem_rdata[ILEN-1:0]
//  MAX_DATA_STREAK  4   max consecutive data grants while a fetch waits (>=1)
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-low reset
//  if_req     in   1     fetch request; held until if_valid or flush
//  if_addr    in   XLEN  fetch address (PC_Out)
//  flush      in   1     taken branch: discard the outstanding/pending fetch
//  if_instr   out  ILEN  fetched instruction
//  if_valid   out  1     1-cycle pulse, if_instr valid
//  d_req      in   1     data request (MemRead|MemWrite); held until d_valid
//  d_we       in   1     1 = store
//  d_addr     in   XLEN  data address (EX_MEM_Result)
//  d_wdata    in   XLEN  store data
//  d_rdata    out  XLEN  load data
//  d_valid    out  1     1-cycle pulse, access complete
//  mem_req    out  1     memory request, registered
//  mem_we     out  1     memory write enable, registered
//  mem_addr   out  XLEN  registered
//  mem_wdata  out  XLEN  registered
//  mem_rdata  in   XLEN  memory read data, valid with mem_ready
//  mem_ready  in   1     memory completion, >=1 cycle after mem_req rises
//  stall_if   out  1     if_req & ~if_valid (combinational)
//  stall_mem  out  1     d_req & ~d_valid (combinational)
// BEHAVIOUR
//  Reset (reset==0): FSM=IDLE, streak=0, drop=0; all registered outputs 0.
//   Reset mid-transaction abandons it; the memory is reset by the same reset.
//  FSM IDLE:
//   - d_req and (streak<MAX_DATA_STREAK or ~if_req): grant data, go BUSY_D.
//   - else if_req & ~flush: grant fetch, go BUSY_I.
//   - Grant registers mem_req=1, mem_we (0 for fetch), mem_addr, mem_wdata.
//  BUSY_x: mem_* held stable until mem_ready.
//   - On mem_ready: mem_req<=0, pulse x_valid for 1 cycle, go IDLE.
//   - One mandatory IDLE bubble between transactions.
//  Data: d_rdata<=mem_rdata on read completion only; stores leave d_rdata unchanged.
//  Streak counter:
//   - +1 (saturating) on each data grant made while if_req=1.
//   - Cleared on a fetch grant, or in any cycle with if_req=0.
//  Flush:
//   - IDLE: blocks a fetch grant that cycle.
//   - BUSY_I, incl. the same cycle as mem_ready: sets drop. The memory access
//     still completes; if_valid is suppressed; drop clears on completion.
//  Latency: request seen in IDLE -> valid >= 2 cycles (grant edge, ready edge).
//  Simultaneous if_req/d_req in IDLE: data wins unless the streak limit is reached.
//  Requests arriving while BUSY wait; no queueing beyond the held req level.
// STRUCTURE
//  Shared package (mem_arb_pkg): state encoding IDLE=2'd0, BUSY_I=2'd1,
//   BUSY_D=2'd2; XLEN/ILEN constants.
//  Single module; no sub-module. Grant decision is one always block;
//   the FSM and capture registers are a second, async-reset always block.
// TESTING
//  1 Fetch only: if_req, if_addr=0x10, ready after 1 cycle, rdata=0x00500093
//    -> if_instr=0x00500093, if_valid 1 cycle, mem_we=0, stall_if high until the pulse.
//  2 Load vs fetch: d_req (read, 0x20) and if_req the same cycle
//    -> data granted first, d_rdata=0xDEAD, then fetch granted after 1 IDLE bubble.
//  3 Starvation: d_req held for 6 back-to-back loads with if_req=1
//    -> exactly 4 data grants, then 1 fetch grant, then data resumes.
//  4 Store: d_we=1, d_addr=0x28, d_wdata=0x5 -> mem_we=1, mem_wdata=0x5 stable
//    until ready; d_valid pulses; d_rdata unchanged.
//  5 Flush in BUSY_I, incl. the mem_ready cycle -> no if_valid; next fetch
//    (0x40) granted and returns normally.
//  6 reset=0 during BUSY_D -> all outputs 0 asynchronously; after release,
//    IDLE with streak=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// state encoding and default datapath widths.
package mem_arb_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int MAX_DATA_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the IF-stage fetch and the
// MEM-stage load/store, one transaction at a time, with a bounded data streak.
module mem_port_arbiter #(
  parameter int XLEN            = mem_arb_pkg::XLEN,
  parameter int ILEN            = mem_arb_pkg::ILEN,
  parameter int MAX_DATA_STREAK = mem_arb_pkg::MAX_DATA_STREAK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            flush,
  output logic [ILEN-1:0] if_instr,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem
);

  import mem_arb_pkg::*;

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e           state_reg;
  logic [STREAK_W-1:0]  streak_reg;
  logic [STREAK_W-1:0]  streak_next;
  logic                 drop_reg;
  logic                 grant_d;
  logic                 grant_i;

  logic                 mem_req_reg;
  logic                 mem_we_reg;
  logic [XLEN-1:0]      mem_addr_reg;
  logic [XLEN-1:0]      mem_wdata_reg;
  logic [ILEN-1:0]      if_instr_reg;
  logic                 if_valid_reg;
  logic [XLEN-1:0]      d_rdata_reg;
  logic                 d_valid_reg;

  // Data wins in IDLE until it has taken MAX_DATA_STREAK grants in a row past
  // a waiting fetch; the streak only builds while a fetch is actually waiting.
  always_comb begin
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    streak_next = streak_reg;
    if (state_reg == IDLE) begin
      if (d_req && ((streak_reg < STREAK_MAX) || !if_req)) begin
        grant_d = 1'b1;
      end else if (if_req && !flush) begin
        grant_i = 1'b1;
      end
    end
    if (!if_req || grant_i) begin
      streak_next = '0;
    end else if (grant_d && (streak_reg < STREAK_MAX)) begin
      streak_next = streak_reg + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      drop_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_instr_reg  <= '0;
      if_valid_reg  <= 1'b0;
      d_rdata_reg   <= '0;
      d_valid_reg   <= 1'b0;
    end else begin
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      streak_reg   <= streak_next;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg     <= BUSY_D;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= d_we;
            mem_addr_reg  <= d_addr;
            mem_wdata_reg <= d_wdata;
          end else if (grant_i) begin
            state_reg     <= BUSY_I;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= if_addr;
            mem_wdata_reg <= '0;
          end
        end
        BUSY_I: begin
          // A flush on the completion cycle itself must still kill the result.
          if (mem_ready) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            drop_reg    <= 1'b0;
            if (!(drop_reg || flush)) begin
              if_valid_reg <= 1'b1;
              if_instr_reg <= mem_rdata[ILEN-1:0];
            end
          end else if (flush) begin
            drop_reg <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            d_valid_reg <= 1'b1;
            if (!mem_we_reg) begin
              d_rdata_reg <= mem_rdata;
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_instr  = if_instr_reg;
  assign if_valid  = if_valid_reg;
  assign d_rdata   = d_rdata_reg;
  assign d_valid   = d_valid_reg;

  assign stall_if  = if_req & ~if_valid_reg;
  assign stall_mem = d_req & ~d_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and returned data are
// queued as stimulus is driven and compared when the arbiter produces them.
module tb_mem_port_arbiter;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [XLEN-1:0] wdata;
    int              gap;
  } grant_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            if_req = 1'b0;
  logic [XLEN-1:0] if_addr = '0;
  logic            flush = 1'b0;
  logic [ILEN-1:0] if_instr;
  logic            if_valid;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [XLEN-1:0] d_addr = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            stall_if;
  logic            stall_mem;

  int checks = 0;
  int errors = 0;

  grant_t          exp_grant_q[$];
  logic [ILEN-1:0] exp_if_q[$];
  logic [XLEN-1:0] exp_d_q[$];
  grant_t          cur_g;

  logic [XLEN-1:0] mem_arr [logic [XLEN-1:0]];
  int              lat = 1;
  int              mcnt = 0;
  int              cycle = 0;
  int              last_grant = -1;
  logic            prev_req = 1'b0;
  logic [XLEN-1:0] last_load;

  mem_port_arbiter #(.XLEN(XLEN), .ILEN(ILEN), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_instr(if_instr), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [XLEN-1:0] rd(input logic [XLEN-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[31:0] ^ 32'hCAFE_0000, a[31:0] + 32'h1111};
  endfunction

  // Memory model: completes each request lat cycles after mem_req is seen.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mcnt      <= 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_req && !mem_ready) begin
        if (mcnt + 1 >= lat) begin
          mem_ready <= 1'b1;
          mcnt      <= 0;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata <= rd(mem_addr);
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  always @(posedge clk) cycle++;

  // Monitor: grants, held request fields and returned data against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_req   = 1'b0;
      last_grant = -1;
    end else begin
      if (mem_req && !prev_req) begin
        check("grant_expected", 64'(exp_grant_q.size() != 0), 64'd1);
        if (exp_grant_q.size() != 0) begin
          cur_g = exp_grant_q.pop_front();
          check("grant_addr", mem_addr, cur_g.addr);
          check("grant_we", 64'(mem_we), 64'(cur_g.we));
          check("grant_wdata", mem_wdata, cur_g.wdata);
          if (cur_g.gap >= 0 && last_grant >= 0)
            check("grant_gap", 64'(cycle - last_grant), 64'(cur_g.gap));
          $display("grant addr=0x%0h we=%0b cycle=%0d", mem_addr, mem_we, cycle);
        end
        last_grant = cycle;
      end else if (mem_req) begin
        check("hold_addr", mem_addr, cur_g.addr);
        check("hold_we", 64'(mem_we), 64'(cur_g.we));
        check("hold_wdata", mem_wdata, cur_g.wdata);
      end
      if (if_valid) begin
        check("if_expected", 64'(exp_if_q.size() != 0), 64'd1);
        if (exp_if_q.size() != 0) check("if_instr", 64'(if_instr), 64'(exp_if_q.pop_front()));
        $display("if_valid instr=0x%0h cycle=%0d", if_instr, cycle);
      end
      if (d_valid) begin
        check("d_expected", 64'(exp_d_q.size() != 0), 64'd1);
        if (exp_d_q.size() != 0) check("d_rdata", d_rdata, exp_d_q.pop_front());
        $display("d_valid rdata=0x%0h cycle=%0d", d_rdata, cycle);
      end
      prev_req = mem_req;
    end
  end

  task automatic push_grant(input logic [XLEN-1:0] a, input logic we, input logic [XLEN-1:0] wd, input int gap);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd; g.gap = gap;
    exp_grant_q.push_back(g);
  endtask

  task automatic fetch_one(input logic [XLEN-1:0] a);
    int n;
    n = 0;
    if_addr = a;
    if_req  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!if_valid) check("stall_if_wait", 64'(stall_if), 64'd1);
    end while (!if_valid && n < 100);
    check("if_done", 64'(if_valid), 64'd1);
    check("stall_if_valid", 64'(stall_if), 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("if_pulse", 64'(if_valid), 64'd0);
  endtask

  task automatic data_stream(input logic [XLEN-1:0] base, input int cnt, input logic we, input logic [XLEN-1:0] wd);
    int n;
    int k;
    n = 0;
    k = 0;
    d_we = we; d_wdata = wd; d_addr = base; d_req = 1'b1;
    while (k < cnt && n < 400) begin
      @(negedge clk);
      n++;
      if (d_valid) begin
        check("stall_mem_valid", 64'(stall_mem), 64'd0);
        k++;
        if (k < cnt) d_addr = base + 64'(8 * k);
        else d_req = 1'b0;
      end else begin
        check("stall_mem_wait", 64'(stall_mem), 64'd1);
      end
    end
    check("d_done", 64'(k), 64'(cnt));
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
  endtask

  // Six loads against one waiting fetch: four data grants, the fetch, then data.
  task automatic run_starve(input logic [XLEN-1:0] base, input logic [XLEN-1:0] fa);
    for (int i = 0; i < 4; i++) push_grant(base + 64'(8 * i), 1'b0, '0, (i == 0) ? -1 : 3);
    push_grant(fa, 1'b0, '0, 3);
    for (int i = 4; i < 6; i++) push_grant(base + 64'(8 * i), 1'b0, '0, 3);
    for (int i = 0; i < 6; i++) exp_d_q.push_back(rd(base + 64'(8 * i)));
    exp_if_q.push_back(rd(fa)[ILEN-1:0]);
    fork
      data_stream(base, 6, 1'b0, '0);
      fetch_one(fa);
    join
    last_load = rd(base + 64'(40));
  endtask

  task automatic wait_cond_req(input logic [XLEN-1:0] a, input string tag);
    int n;
    n = 0;
    while (!(mem_req && mem_addr == a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(mem_req && mem_addr == a), 64'd1);
  endtask

  initial begin
    int n;
    int k;
    logic [XLEN-1:0] v;
    mem_arr[64'h10] = 64'h0000_0000_0050_0093;
    mem_arr[64'h20] = 64'h0000_0000_0000_DEAD;
    mem_arr[64'h28] = 64'h1234;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_d_valid", 64'(d_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_mem_req", 64'(mem_req), 64'd0);
    check("idle_stall_if", 64'(stall_if), 64'd0);

    // 1: fetch only
    lat = 1;
    push_grant(64'h10, 1'b0, '0, -1);
    exp_if_q.push_back(32'h0050_0093);
    fetch_one(64'h10);

    // 2: load and fetch together, data first, fetch after one bubble
    push_grant(64'h20, 1'b0, '0, -1);
    push_grant(64'h30, 1'b0, '0, 3);
    exp_d_q.push_back(64'hDEAD);
    exp_if_q.push_back(rd(64'h30)[ILEN-1:0]);
    fork
      data_stream(64'h20, 1, 1'b0, '0);
      fetch_one(64'h30);
    join
    repeat (2) @(negedge clk);

    // 3: starvation limit
    run_starve(64'h100, 64'h200);
    repeat (2) @(negedge clk);

    // 4: store leaves d_rdata unchanged
    lat = 3;
    push_grant(64'h28, 1'b1, 64'h5, -1);
    exp_d_q.push_back(last_load);
    data_stream(64'h28, 1, 1'b1, 64'h5);
    check("store_mem", rd(64'h28), 64'h5);
    repeat (2) @(negedge clk);

    // 5a: flush while the fetch is in flight
    push_grant(64'h30, 1'b0, '0, -1);
    if_addr = 64'h30; if_req = 1'b1;
    wait_cond_req(64'h30, "flush_a_grant");
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("flush_a_no_valid", 64'(if_valid), 64'd0);
    end

    // 5b: flush on the mem_ready cycle, redirected fetch returns normally
    lat = 2;
    push_grant(64'h38, 1'b0, '0, -1);
    push_grant(64'h40, 1'b0, '0, 4);
    exp_if_q.push_back(rd(64'h40)[ILEN-1:0]);
    if_addr = 64'h38; if_req = 1'b1;
    n = 0;
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("flush_b_ready_seen", 64'(mem_ready), 64'd1);
    flush = 1'b1; if_addr = 64'h40;
    @(negedge clk);
    flush = 1'b0;
    check("flush_b_no_valid", 64'(if_valid), 64'd0);
    fetch_one(64'h40);

    // 5c: flush in IDLE blocks the fetch grant
    if_addr = 64'h48; if_req = 1'b1; flush = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("flush_idle_block", 64'(mem_req), 64'd0);
    end
    push_grant(64'h48, 1'b0, '0, -1);
    exp_if_q.push_back(rd(64'h48)[ILEN-1:0]);
    flush = 1'b0;
    fetch_one(64'h48);
    repeat (2) @(negedge clk);

    // 6: reset in BUSY_D after building a streak of two
    lat = 4;
    push_grant(64'h50, 1'b0, '0, -1);
    push_grant(64'h58, 1'b0, '0, 6);
    push_grant(64'h70, 1'b0, '0, 6);
    exp_d_q.push_back(rd(64'h50));
    exp_d_q.push_back(rd(64'h58));
    if_addr = 64'h60; if_req = 1'b1;
    d_addr = 64'h50; d_req = 1'b1; d_we = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (d_valid) begin
        k++;
        d_addr = (k == 1) ? 64'h58 : 64'h70;
      end
    end
    check("rst_pre_loads", 64'(k), 64'd2);
    wait_cond_req(64'h70, "rst_busy_grant");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_mem_req", 64'(mem_req), 64'd0);
    check("async_mem_addr", mem_addr, '0);
    check("async_d_rdata", d_rdata, '0);
    check("async_if_instr", 64'(if_instr), 64'd0);
    check("async_valids", {62'd0, if_valid, d_valid}, 64'd0);
    exp_grant_q.delete();
    exp_if_q.delete();
    exp_d_q.delete();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(mem_req), 64'd0);
    lat = 1;
    run_starve(64'h300, 64'h208);
    repeat (3) @(negedge clk);
    check("end_grant_q", 64'(exp_grant_q.size()), 64'd0);
    check("end_if_q", 64'(exp_if_q.size()), 64'd0);
    check("end_d_q", 64'(exp_d_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
